squat_pose_animator: RTL and testbench



---
 rtl/squat_pose_animator.sv | 201 ++++++++++++++++++++
 tb/tb_squat_pose_animator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/squat_pose_animator.sv
// Stick-figure squat animator: builds the 14-rect pose for the rasteriser and steps it only at the vsync leading edge.
// Latency: depth/phase settle 1 vgaclk after the tick, rects 2; no backpressure.
module squat_pose_animator #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int STEP_PX         = 4,
    parameter int MAX_DEPTH       = 60,
    parameter int HOLD_STEPS      = 8
) (
    input  logic               vgaclk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               enable,
    output logic [13:0][39:0]  rects,
    output logic [9:0]         depth,
    output logic [2:0]         phase,
    output logic [7:0]         rep_count
);

    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HCW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);
    localparam logic [HCW-1:0] HC_LAST = HCW'(HOLD_STEPS - 1);
    localparam logic [9:0]     STEP_D  = 10'(STEP_PX);
    localparam logic [9:0]     MAX_D   = 10'(MAX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STAND  = 3'd1,
        S_DOWN   = 3'd2,
        S_BOTTOM = 3'd3,
        S_UP     = 3'd4
    } state_t;

    typedef struct packed {
        logic [9:0] left;
        logic [9:0] right;
        logic [9:0] top;
        logic [9:0] bot;
    } rect_t;

    typedef rect_t [13:0] rect_arr_t;

    function automatic rect_t mk_rect(input logic [9:0] l, input logic [9:0] r,
                                      input logic [9:0] t, input logic [9:0] b);
        rect_t x;
        x.left  = l;
        x.right = r;
        x.top   = t;
        x.bot   = b;
        return x;
    endfunction

    // Upper body drops rigidly by d; legs keep their feet at y=300 and shorten.
    function automatic rect_arr_t pose(input logic [9:0] d);
        rect_arr_t p;
        p    = '0;
        p[0] = mk_rect(10'd300, 10'd340, 10'd100 + d, 10'd140 + d);
        p[1] = mk_rect(10'd310, 10'd330, 10'd140 + d, 10'd220 + d);
        p[2] = mk_rect(10'd270, 10'd310, 10'd150 + d, 10'd170 + d);
        p[3] = mk_rect(10'd330, 10'd370, 10'd150 + d, 10'd170 + d);
        p[4] = mk_rect(10'd310, 10'd320, 10'd220 + d, 10'd300);
        p[5] = mk_rect(10'd320, 10'd330, 10'd220 + d, 10'd300);
        return p;
    endfunction

    logic           r_vsync_q;
    state_t         r_state;
    logic [FCW-1:0] r_fc;
    logic [HCW-1:0] r_hc;
    logic [9:0]     r_d;
    logic [7:0]     r_rep;
    logic           r_abort;
    rect_arr_t      r_rects;

    state_t         w_state_nx;
    logic [FCW-1:0] w_fc_nx;
    logic [HCW-1:0] w_hc_nx;
    logic [9:0]     w_d_nx;
    logic [7:0]     w_rep_nx;
    logic           w_abort_nx;
    logic           w_frame_tick;
    logic           w_step;
    logic [9:0]     w_d_up;
    logic [9:0]     w_d_dn;

    assign w_frame_tick = r_vsync_q & ~vsync;
    assign w_step       = w_frame_tick && (r_fc == FC_LAST) && (r_state != S_IDLE);
    assign w_d_up       = r_d + STEP_D;
    assign w_d_dn       = (r_d > STEP_D) ? (r_d - STEP_D) : 10'd0;

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            r_vsync_q <= 1'b1;
            r_state   <= S_IDLE;
            r_fc      <= '0;
            r_hc      <= '0;
            r_d       <= '0;
            r_rep     <= '0;
            r_abort   <= 1'b0;
            r_rects   <= pose(10'd0);
        end else begin
            r_vsync_q <= vsync;
            r_state   <= w_state_nx;
            r_fc      <= w_fc_nx;
            r_hc      <= w_hc_nx;
            r_d       <= w_d_nx;
            r_rep     <= w_rep_nx;
            r_abort   <= w_abort_nx;
            r_rects   <= pose(r_d);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_fc_nx    = r_fc;
        w_hc_nx    = r_hc;
        w_d_nx     = r_d;
        w_rep_nx   = r_rep;
        w_abort_nx = r_abort;

        if (r_state == S_IDLE) begin
            w_fc_nx = '0;
        end else if (w_frame_tick) begin
            w_fc_nx = (r_fc == FC_LAST) ? '0 : r_fc + FCW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_frame_tick && enable) begin
                    w_state_nx = S_STAND;
                    w_hc_nx    = '0;
                    w_d_nx     = '0;
                    w_abort_nx = 1'b0;
                end
            end
            S_STAND: begin
                if (w_step) begin
                    if (!enable) begin
                        w_state_nx = S_IDLE;
                        w_hc_nx    = '0;
                    end else if (r_hc == HC_LAST) begin
                        w_state_nx = S_DOWN;
                        w_hc_nx    = '0;
                    end else begin
                        w_hc_nx = r_hc + HCW'(1);
                    end
                end
            end
            S_DOWN, S_BOTTOM: begin
                if (w_step) begin
                    if (!enable) begin
                        // Abort: this step already counts as the first ascent step.
                        w_d_nx = w_d_dn;
                        if (w_d_dn == 10'd0) begin
                            w_state_nx = S_IDLE;
                            w_abort_nx = 1'b0;
                        end else begin
                            w_state_nx = S_UP;
                            w_abort_nx = 1'b1;
                        end
                    end else if (r_state == S_DOWN) begin
                        if (w_d_up >= MAX_D) begin
                            w_d_nx     = MAX_D;
                            w_state_nx = S_BOTTOM;
                            w_hc_nx    = '0;
                        end else begin
                            w_d_nx = w_d_up;
                        end
                    end else if (r_hc == HC_LAST) begin
                        w_state_nx = S_UP;
                        w_hc_nx    = '0;
                    end else begin
                        w_hc_nx = r_hc + HCW'(1);
                    end
                end
            end
            S_UP: begin
                if (w_step) begin
                    w_d_nx = w_d_dn;
                    if (w_d_dn == 10'd0) begin
                        if (!r_abort && (r_rep != 8'hFF)) begin
                            w_rep_nx = r_rep + 8'd1;
                        end
                        w_abort_nx = 1'b0;
                        w_hc_nx    = '0;
                        w_state_nx = enable ? S_STAND : S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign rects     = r_rects;
    assign depth     = r_d;
    assign phase     = r_state;
    assign rep_count = r_rep;

endmodule

// File: tb/tb_squat_pose_animator.sv
// Directed bench: default-parameter instance walks a full rep, abort and reset;
// a fast instance (1 frame/step, 20 px) checks tick edges and rep saturation.
module tb_squat_pose_animator;

    logic              vgaclk;
    logic              reset;
    logic              vsync;
    logic              enable_a;
    logic              enable_b;
    logic [13:0][39:0] rects_a;
    logic [13:0][39:0] rects_b;
    logic [9:0]        depth_a;
    logic [9:0]        depth_b;
    logic [2:0]        phase_a;
    logic [2:0]        phase_b;
    logic [7:0]        rep_a;
    logic [7:0]        rep_b;

    int vectors;
    int miscompares;
    int ft;

    squat_pose_animator u_a (
        .vgaclk    (vgaclk),
        .reset     (reset),
        .vsync     (vsync),
        .enable    (enable_a),
        .rects     (rects_a),
        .depth     (depth_a),
        .phase     (phase_a),
        .rep_count (rep_a)
    );

    squat_pose_animator #(
        .FRAMES_PER_STEP (1),
        .STEP_PX         (20),
        .MAX_DEPTH       (60),
        .HOLD_STEPS      (1)
    ) u_b (
        .vgaclk    (vgaclk),
        .reset     (reset),
        .vsync     (vsync),
        .enable    (enable_b),
        .rects     (rects_b),
        .depth     (depth_b),
        .phase     (phase_b),
        .rep_count (rep_b)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    function automatic logic [39:0] rc(input int l, input int r, input int t, input int b);
        return {10'(l), 10'(r), 10'(t), 10'(b)};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One frame: vsync low for low_cyc cycles then high for 3; starts and ends at a negedge.
    task automatic frame(input int low_cyc);
        vsync = 1'b0;
        repeat (low_cyc) @(negedge vgaclk);
        vsync = 1'b1;
        repeat (3) @(negedge vgaclk);
        ft++;
    endtask

    task automatic adv(input int t);
        while (ft <= t) frame(2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ft          = 0;
        reset       = 1'b1;
        vsync       = 1'b1;
        enable_a    = 1'b0;
        enable_b    = 1'b0;
        repeat (3) @(negedge vgaclk);

        chk("rst_phase", 40'(phase_a), 40'd0);
        chk("rst_depth", 40'(depth_a), 40'd0);
        chk("rst_rep",   40'(rep_a),   40'd0);
        chk("rst_head",  rects_a[0],   rc(300, 340, 100, 140));
        reset = 1'b0;
        @(negedge vgaclk);

        repeat (10) frame(2);
        chk("idle_phase", 40'(phase_a), 40'd0);
        chk("idle_depth", 40'(depth_a), 40'd0);
        chk("idle_head",  rects_a[0],   rc(300, 340, 100, 140));
        chk("idle_lleg",  rects_a[4],   rc(310, 320, 220, 300));
        chk("idle_r13",   rects_a[13],  40'd0);

        // Full rep on the default instance; tick T0 is the first with enable high.
        ft       = 0;
        enable_a = 1'b1;
        adv(0);
        chk("t0_phase",  40'(phase_a), 40'd1);
        adv(15);
        chk("t15_phase", 40'(phase_a), 40'd1);
        chk("t15_depth", 40'(depth_a), 40'd0);
        adv(16);
        chk("t16_phase", 40'(phase_a), 40'd2);
        chk("t16_depth", 40'(depth_a), 40'd0);
        adv(17);
        chk("t17_depth", 40'(depth_a), 40'd0);
        adv(18);
        chk("t18_depth", 40'(depth_a), 40'd4);
        adv(44);
        chk("t44_depth", 40'(depth_a), 40'd56);
        adv(45);

        // Tick T46 by hand to observe the two-edge geometry latency.
        vsync = 1'b0;
        @(negedge vgaclk);
        chk("t46_e1_depth", 40'(depth_a), 40'd60);
        chk("t46_e1_body",  rects_a[1],   rc(310, 330, 196, 276));
        @(negedge vgaclk);
        chk("t46_e2_body",  rects_a[1],   rc(310, 330, 200, 280));
        chk("t46_e2_rleg",  rects_a[5],   rc(320, 330, 280, 300));
        chk("t46_phase",    40'(phase_a), 40'd3);
        vsync = 1'b1;
        repeat (3) @(negedge vgaclk);
        ft++;

        adv(61);
        chk("t61_phase", 40'(phase_a), 40'd3);
        adv(62);
        chk("t62_phase", 40'(phase_a), 40'd4);
        chk("t62_depth", 40'(depth_a), 40'd60);
        adv(64);
        chk("t64_depth", 40'(depth_a), 40'd56);
        adv(91);
        chk("t91_depth", 40'(depth_a), 40'd4);
        chk("t91_rep",   40'(rep_a),   40'd0);
        adv(92);
        chk("t92_phase", 40'(phase_a), 40'd1);
        chk("t92_depth", 40'(depth_a), 40'd0);
        chk("t92_rep",   40'(rep_a),   40'd1);
        chk("t92_head",  rects_a[0],   rc(300, 340, 100, 140));

        // Abort during descent at d=32.
        adv(124);
        chk("t124_depth", 40'(depth_a), 40'd32);
        enable_a = 1'b0;
        adv(125);
        chk("t125_phase", 40'(phase_a), 40'd2);
        chk("t125_depth", 40'(depth_a), 40'd32);
        adv(126);
        chk("t126_phase", 40'(phase_a), 40'd4);
        chk("t126_depth", 40'(depth_a), 40'd28);
        adv(139);
        chk("t139_depth", 40'(depth_a), 40'd4);
        adv(140);
        chk("t140_phase", 40'(phase_a), 40'd0);
        chk("t140_depth", 40'(depth_a), 40'd0);
        chk("t140_rep",   40'(rep_a),   40'd1);

        // Restart, then reset asynchronously at d=40.
        enable_a = 1'b1;
        adv(141);
        chk("t141_phase", 40'(phase_a), 40'd1);
        adv(177);
        chk("t177_depth", 40'(depth_a), 40'd40);
        chk("t177_body",  rects_a[1],   rc(310, 330, 180, 260));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_depth", 40'(depth_a), 40'd0);
        chk("arst_phase", 40'(phase_a), 40'd0);
        chk("arst_rep",   40'(rep_a),   40'd0);
        chk("arst_body",  rects_a[1],   rc(310, 330, 140, 220));
        chk("arst_lleg",  rects_a[4],   rc(310, 320, 220, 300));
        @(negedge vgaclk);
        reset    = 1'b0;
        enable_a = 1'b0;
        @(negedge vgaclk);

        // Fast instance: one step per frame, 20 px, one-step holds.
        ft       = 0;
        enable_b = 1'b1;
        adv(0);
        chk("b_t0_phase", 40'(phase_b), 40'd1);
        adv(1);
        chk("b_t1_phase", 40'(phase_b), 40'd2);
        chk("b_t1_depth", 40'(depth_b), 40'd0);
        adv(2);
        chk("b_t2_depth", 40'(depth_b), 40'd20);
        frame(20);
        chk("b_longlow_depth", 40'(depth_b), 40'd40);
        adv(4);
        chk("b_t4_depth", 40'(depth_b), 40'd60);
        chk("b_t4_phase", 40'(phase_b), 40'd3);
        chk("b_t4_head",  rects_b[0],   rc(300, 340, 160, 200));
        adv(8);
        chk("b_t8_rep",   40'(rep_b),   40'd1);
        adv(2032);
        chk("b_rep254",   40'(rep_b),   40'd254);
        adv(2040);
        chk("b_rep255",   40'(rep_b),   40'd255);
        adv(2047);
        chk("b_t2047_depth", 40'(depth_b), 40'd20);
        adv(2048);
        chk("b_rep_sat",   40'(rep_b),   40'd255);
        chk("b_t2048_phase", 40'(phase_b), 40'd1);
        chk("a_idle_while_b", 40'(phase_a), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
